// File: rtl/uart_fifoed_recv.sv
// uart_fifoed_recv: UART receiver (start, 8 data bits LSB first, optional even
// parity, stop) feeding a first-word fall-through byte FIFO.
//
// Optional feature: define UART_RECV_PARITY_EN to expect an even-parity bit
// between the last data bit and the stop bit. Without it, parity_err is tied 0.
//
// Ports:
//   clk_100MHz  in   single clock, rising edge
//   reset       in   asynchronous, active-high reset
//   RX          in   asynchronous serial line, idles high
//   dat_rd      in   pop the FIFO head byte (ignored when empty)
//   dat         out  FIFO head byte, 8'h00 when empty
//   fifo_empty  out  FIFO holds 0 bytes
//   fifo_afull  out  FIFO holds at least fifo_almost bytes
//   fifo_full   out  FIFO holds fifo_size bytes
//   frame_err   out  one-cycle pulse: stop bit sampled 0
//   overrun     out  one-cycle pulse: received byte dropped, FIFO full
//   parity_err  out  one-cycle pulse: parity mismatch (parity builds only)
`timescale 1ns/1ps

module uart_fifoed_recv #(
    parameter int unsigned fifo_size       = 4096,
    parameter int unsigned fifo_almost     = 4090,
    parameter int unsigned baudrate        = 921600,
    parameter int unsigned clock_frequency = 100000000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       RX,
    input  logic       dat_rd,
    output logic [7:0] dat,
    output logic       fifo_empty,
    output logic       fifo_afull,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned D     = clock_frequency / baudrate;
    localparam int unsigned CNT_W = (D > 2) ? $clog2(D) : 1;
    localparam int unsigned IDX_W = (fifo_size > 1) ? $clog2(fifo_size) : 1;
    localparam int unsigned LVL_W = $clog2(fifo_size + 1);

`ifdef UART_RECV_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t             state_q, state_d;
    logic               rx_meta_q, rxs_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               push_req_c, push_c, pop_c;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               empty_q, afull_q, full_q;
    logic [7:0]         mem [fifo_size];
`ifdef UART_RECV_PARITY_EN
    logic               par_bad_q, par_bad_d;
    logic               parity_err_q, parity_err_d;
`endif

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(fifo_size - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rxs_q     <= rx_meta_q;
        end
    end

    // Receiver state register
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RECV_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Receiver next state; counter loaded to D/2-1 at the start edge so every
    // later sample lands mid-bit
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_req_c  = 1'b0;
`ifdef UART_RECV_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    cnt_d   = CNT_W'(D / 2 - 1);
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = CNT_W'(D - 1);
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = CNT_W'(D - 1);
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_RECV_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    // Even parity: the parity bit must equal the XOR of the data
                    par_bad_d = rxs_q ^ (^shift_q);
                    cnt_d     = CNT_W'(D - 1);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (!rxs_q) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
`ifdef UART_RECV_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        push_req_c = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO control; a pop in the same cycle frees room for a write into a full FIFO
    always_comb begin
        pop_c     = dat_rd && !empty_q;
        push_c    = push_req_c && (!full_q || pop_c);
        overrun_d = push_req_c && !push_c;
        wr_idx_d  = push_c ? next_idx(wr_idx_q) : wr_idx_q;
        rd_idx_d  = pop_c ? next_idx(rd_idx_q) : rd_idx_q;
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers, level and registered status flags
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            level_q  <= level_d;
            empty_q  <= (level_d == '0);
            afull_q  <= (level_d >= LVL_W'(fifo_almost));
            full_q   <= (level_d == LVL_W'(fifo_size));
        end
    end

    // Storage array, no reset needed: contents are only visible when level > 0
    always_ff @(posedge clk_100MHz) begin
        if (push_c) begin
            mem[wr_idx_q] <= shift_q;
        end
    end

    assign dat        = empty_q ? 8'h00 : mem[rd_idx_q];
    assign fifo_empty = empty_q;
    assign fifo_afull = afull_q;
    assign fifo_full  = full_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RECV_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifoed_recv.sv
// tb_uart_fifoed_recv: self-checking bench for uart_fifoed_recv with D=10,
// fifo_size=4, fifo_almost=3. Directed table, hand-written corner sequences,
// then random frames against a queue model of the FIFO.
`timescale 1ns/1ps

module tb_uart_fifoed_recv;

    localparam int unsigned D   = 10;
    localparam int unsigned FSZ = 4;
    localparam int unsigned FAL = 3;
`ifdef UART_RECV_PARITY_EN
    localparam int unsigned NPAR = 1;
`else
    localparam int unsigned NPAR = 0;
`endif
    // Clock edges from the start-bit drive to the stop-bit sample
    localparam int unsigned STOP_OFS = 97 + 10 * NPAR;

    logic       clk = 1'b0;
    logic       reset, rx, dat_rd;
    logic [7:0] dat;
    logic       fifo_empty, fifo_afull, fifo_full, frame_err, overrun, parity_err;

    int checks = 0;
    int errors = 0;
    int ferr_n = 0, ovr_n = 0, perr_n = 0;

    uart_fifoed_recv #(
        .fifo_size      (FSZ),
        .fifo_almost    (FAL),
        .baudrate       (10000000),
        .clock_frequency(100000000)
    ) dut (
        .clk_100MHz(clk),
        .reset     (reset),
        .RX        (rx),
        .dat_rd    (dat_rd),
        .dat       (dat),
        .fifo_empty(fifo_empty),
        .fifo_afull(fifo_afull),
        .fifo_full (fifo_full),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Pulse counters: each high cycle counts as one event
    always @(negedge clk) begin
        if (frame_err)  ferr_n++;
        if (overrun)    ovr_n++;
        if (parity_err) perr_n++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip);
        rx = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (D) @(negedge clk);
        end
        if (NPAR != 0) begin
            rx = (^b) ^ par_flip;
            repeat (D) @(negedge clk);
        end
        rx = stop_bit;
        repeat (D) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_pop();
        dat_rd = 1'b1;
        @(negedge clk);
        dat_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_flags(input string nm, input logic [7:0] e_dat, input bit e_empty,
                             input bit e_afull, input bit e_full);
        chk({nm, " dat"},   32'(dat),        32'(e_dat));
        chk({nm, " empty"}, 32'(fifo_empty), 32'(e_empty));
        chk({nm, " afull"}, 32'(fifo_afull), 32'(e_afull));
        chk({nm, " full"},  32'(fifo_full),  32'(e_full));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk_flags(nm, 8'h00, 1'b1, 1'b0, 1'b0);
        chk({nm, " ferr"}, 32'(frame_err),  32'(0));
        chk({nm, " ovr"},  32'(overrun),    32'(0));
        chk({nm, " perr"}, 32'(parity_err), 32'(0));
    endtask

    typedef struct {
        bit         pop;
        logic [7:0] data;
        bit         stop;
        logic [7:0] e_dat;
        bit         e_empty;
        bit         e_afull;
        bit         e_full;
        int         e_ferr;
        int         e_ovr;
    } vec_t;

    vec_t tbl [15];
    byte unsigned mq [$];

    initial begin
        int f0, o0, p0;
        logic [7:0] b;
        bit stop;
        logic [7:0] head;

        //            pop  data   stop  dat    emp  afl  ful  ferr ovr
        tbl[0]  = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1'b0, 8'h02, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{1'b0, 8'h03, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[4]  = '{1'b0, 8'h04, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 0, 0};
        tbl[5]  = '{1'b0, 8'h05, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 0, 1};
        tbl[6]  = '{1'b1, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[7]  = '{1'b1, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[8]  = '{1'b0, 8'h3C, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1, 0};
        tbl[9]  = '{1'b0, 8'h7E, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[10] = '{1'b1, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[11] = '{1'b1, 8'h00, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[12] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[13] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[14] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0};

        reset  = 1'b1;
        rx     = 1'b1;
        dat_rd = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Directed table: fill, overrun, frame error, wrap, drain
        for (int i = 0; i < 15; i++) begin
            f0 = ferr_n;
            o0 = ovr_n;
            if (tbl[i].pop) do_pop();
            else            send_frame(tbl[i].data, tbl[i].stop, 1'b0);
            chk_flags($sformatf("tbl%0d", i), tbl[i].e_dat, tbl[i].e_empty,
                      tbl[i].e_afull, tbl[i].e_full);
            chk($sformatf("tbl%0d ferr", i), 32'(ferr_n - f0), 32'(tbl[i].e_ferr));
            chk($sformatf("tbl%0d ovr", i),  32'(ovr_n - o0),  32'(tbl[i].e_ovr));
        end

        // Byte appears exactly one cycle after the stop-bit sample
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (STOP_OFS) @(negedge clk);
                chk("lat before", 32'(fifo_empty), 32'(1));
                @(negedge clk);
                chk("lat empty", 32'(fifo_empty), 32'(0));
                chk("lat dat",   32'(dat),        32'(8'hA5));
            end
        join
        do_pop();
        chk("lat pop empty", 32'(fifo_empty), 32'(1));
        chk("lat pop dat",   32'(dat),        32'(8'h00));

        // Short low glitch on idle line: nothing happens
        f0 = ferr_n; o0 = ovr_n; p0 = perr_n;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * D) @(negedge clk);
        chk("glitch empty", 32'(fifo_empty), 32'(1));
        chk("glitch flags", 32'(ferr_n - f0 + ovr_n - o0 + perr_n - p0), 32'(0));

        // Write into a full FIFO while popping: accepted, level unchanged
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        chk("full pre", 32'(fifo_full), 32'(1));
        o0 = ovr_n;
        fork
            send_frame(8'h99, 1'b1, 1'b0);
            begin
                repeat (STOP_OFS) @(negedge clk);
                dat_rd = 1'b1;
                @(negedge clk);
                dat_rd = 1'b0;
            end
        join
        chk("fullrw ovr",  32'(ovr_n - o0), 32'(0));
        chk("fullrw full", 32'(fifo_full),  32'(1));
        chk("fullrw dat",  32'(dat),        32'(8'h22));
        do_pop(); chk("fullrw d1", 32'(dat), 32'(8'h33));
        do_pop(); chk("fullrw d2", 32'(dat), 32'(8'h44));
        do_pop(); chk("fullrw d3", 32'(dat), 32'(8'h99));
        do_pop(); chk("fullrw end", 32'(fifo_empty), 32'(1));

        // Reset in the middle of data bit 4 of 8'hFF
        send_frame(8'h5A, 1'b1, 1'b0);
        f0 = ferr_n; o0 = ovr_n;
        rx = 1'b0;
        repeat (D) @(negedge clk);
        rx = 1'b1;
        repeat (4 * D + D / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6 * D) @(negedge clk);
        chk("midrst empty", 32'(fifo_empty), 32'(1));
        chk("midrst flags", 32'(ferr_n - f0 + ovr_n - o0), 32'(0));
        send_frame(8'h12, 1'b1, 1'b0);
        chk("midrst dat", 32'(dat), 32'(8'h12));
        do_pop();
        chk("midrst only", 32'(fifo_empty), 32'(1));

`ifdef UART_RECV_PARITY_EN
        // Wrong parity bit drops the byte; correct parity accepts it
        p0 = perr_n;
        send_frame(8'h03, 1'b1, 1'b1);
        chk("par bad perr",  32'(perr_n - p0), 32'(1));
        chk("par bad empty", 32'(fifo_empty),  32'(1));
        p0 = perr_n;
        send_frame(8'h03, 1'b1, 1'b0);
        chk("par ok perr", 32'(perr_n - p0), 32'(0));
        chk("par ok dat",  32'(dat),         32'(8'h03));
        do_pop();
`endif

        // Random frames and pops against a queue model
        mq.delete();
        for (int n = 0; n < 30; n++) begin
            int npop;
            npop = ($urandom_range(0, 3) == 0) ? 2 : int'($urandom_range(0, 1));
            for (int k = 0; k < npop; k++) begin
                do_pop();
                if (mq.size() > 0) void'(mq.pop_front());
            end
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            f0 = ferr_n; o0 = ovr_n;
            send_frame(b, stop, 1'b0);
            chk($sformatf("rnd%0d ferr", n), 32'(ferr_n - f0), 32'(!stop));
            chk($sformatf("rnd%0d ovr", n), 32'(ovr_n - o0),
                32'(stop && (mq.size() == FSZ)));
            if (stop && (mq.size() < FSZ)) mq.push_back(b);
            head = (mq.size() > 0) ? 8'(mq[0]) : 8'h00;
            chk_flags($sformatf("rnd%0d", n), head, mq.size() == 0,
                      mq.size() >= FAL, mq.size() == FSZ);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
